// File: rtl/regfile_scoreboard.sv
// Dual-write register file with per-register busy bits for outstanding loads; reads and busy are combinational with same-cycle write bypass.
// Writes/reserves take effect at the clock edge; there is no backpressure (all ports are always accepted).
module regfile_scoreboard #(
  parameter int BIT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrEn0,
  input  logic [ADDR_WIDTH-1:0] wrAddr0,
  input  logic [BIT_WIDTH-1:0]  wrData0,
  input  logic                  wrEn1,
  input  logic [ADDR_WIDTH-1:0] wrAddr1,
  input  logic [BIT_WIDTH-1:0]  wrData1,
  input  logic [ADDR_WIDTH-1:0] readAddr1,
  input  logic [ADDR_WIDTH-1:0] readAddr2,
  output logic [BIT_WIDTH-1:0]  readData1,
  output logic [BIT_WIDTH-1:0]  readData2,
  input  logic                  reserveEn,
  input  logic [ADDR_WIDTH-1:0] reserveAddr,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  busyAny
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [BIT_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]     r_busy;

  logic w_we0, w_we1, w_rsv, w_zero1, w_zero2;

  // Register 0 is immune to writes and reservations when hardwired.
  assign w_we0   = wrEn0 && !(ZERO_REG != 0 && wrAddr0 == '0);
  assign w_we1   = wrEn1 && !(ZERO_REG != 0 && wrAddr1 == '0);
  assign w_rsv   = reserveEn && !(ZERO_REG != 0 && reserveAddr == '0);
  assign w_zero1 = (ZERO_REG != 0) && (readAddr1 == '0);
  assign w_zero2 = (ZERO_REG != 0) && (readAddr2 == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_we0) r_regs[wrAddr0] <= wrData0;
      if (w_we1) r_regs[wrAddr1] <= wrData1;
      if (w_we1) r_busy[wrAddr1] <= 1'b0;
      // Set after clear so a fresh reservation beats a returning load.
      if (w_rsv) r_busy[reserveAddr] <= 1'b1;
    end
  end

  always_comb begin
    readData1 = r_regs[readAddr1];
    if (w_zero1)                              readData1 = '0;
    else if (wrEn1 && wrAddr1 == readAddr1)   readData1 = wrData1;
    else if (wrEn0 && wrAddr0 == readAddr1)   readData1 = wrData0;
  end

  always_comb begin
    readData2 = r_regs[readAddr2];
    if (w_zero2)                              readData2 = '0;
    else if (wrEn1 && wrAddr1 == readAddr2)   readData2 = wrData1;
    else if (wrEn0 && wrAddr0 == readAddr2)   readData2 = wrData0;
  end

  assign busy1   = r_busy[readAddr1] && !(wrEn1 && wrAddr1 == readAddr1);
  assign busy2   = r_busy[readAddr2] && !(wrEn1 && wrAddr1 == readAddr2);
  assign busyAny = |r_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: one instance with ZERO_REG=1 and one with ZERO_REG=0 share stimulus.
// Expectations are queued as stimulus is driven and compared against the selected output at the following negedge.
module tb_regfile_scoreboard;

  localparam int BW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wrEn0, wrEn1, reserveEn;
  logic [AW-1:0] wrAddr0, wrAddr1, readAddr1, readAddr2, reserveAddr;
  logic [BW-1:0] wrData0, wrData1;

  logic [BW-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic          b1_a, b2_a, ba_a, b1_b, b2_b, ba_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef enum int {S_RD1, S_RD2, S_B1, S_B2, S_BANY, S_Z_RD1, S_Z_B1, S_Z_BANY} sel_t;
  string         q_tag[$];
  sel_t          q_sel[$];
  logic [BW-1:0] q_val[$];

  always #5 clk = ~clk;

  regfile_scoreboard #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst),
    .wrEn0(wrEn0), .wrAddr0(wrAddr0), .wrData0(wrData0),
    .wrEn1(wrEn1), .wrAddr1(wrAddr1), .wrData1(wrData1),
    .readAddr1(readAddr1), .readAddr2(readAddr2),
    .readData1(rd1_a), .readData2(rd2_a),
    .reserveEn(reserveEn), .reserveAddr(reserveAddr),
    .busy1(b1_a), .busy2(b2_a), .busyAny(ba_a)
  );

  regfile_scoreboard #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW), .ZERO_REG(0)) u_dut_z0 (
    .clk(clk), .rst(rst),
    .wrEn0(wrEn0), .wrAddr0(wrAddr0), .wrData0(wrData0),
    .wrEn1(wrEn1), .wrAddr1(wrAddr1), .wrData1(wrData1),
    .readAddr1(readAddr1), .readAddr2(readAddr2),
    .readData1(rd1_b), .readData2(rd2_b),
    .reserveEn(reserveEn), .reserveAddr(reserveAddr),
    .busy1(b1_b), .busy2(b2_b), .busyAny(ba_b)
  );

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] observe(input sel_t s);
    case (s)
      S_RD1:    return rd1_a;
      S_RD2:    return rd2_a;
      S_B1:     return {{(BW-1){1'b0}}, b1_a};
      S_B2:     return {{(BW-1){1'b0}}, b2_a};
      S_BANY:   return {{(BW-1){1'b0}}, ba_a};
      S_Z_RD1:  return rd1_b;
      S_Z_B1:   return {{(BW-1){1'b0}}, b1_b};
      default:  return {{(BW-1){1'b0}}, ba_b};
    endcase
  endfunction

  task automatic expect_out(input string tag, input sel_t s, input logic [BW-1:0] v);
    q_tag.push_back(tag);
    q_sel.push_back(s);
    q_val.push_back(v);
  endtask

  task automatic drain();
    while (q_sel.size() > 0) begin
      string         t;
      sel_t          s;
      logic [BW-1:0] v;
      t = q_tag.pop_front();
      s = q_sel.pop_front();
      v = q_val.pop_front();
      chk(t, observe(s), v);
    end
  endtask

  task automatic idle();
    wrEn0 = 1'b0; wrEn1 = 1'b0; reserveEn = 1'b0;
    wrAddr0 = '0; wrAddr1 = '0; reserveAddr = '0;
    wrData0 = '0; wrData1 = '0;
  endtask

  // Advance to just after the next rising edge so new stimulus lands mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    readAddr1 = '0; readAddr2 = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("rst_busyAny", S_BANY, 0);
    expect_out("rst_rd1", S_RD1, 0);
    sample();
    next_cycle();
    rst = 1'b0;

    // Every address reads back zero and idle after reset.
    for (int a = 0; a < 32; a++) begin
      next_cycle();
      readAddr1 = AW'(a);
      readAddr2 = AW'(31 - a);
      expect_out($sformatf("rst_rd1_%0d", a), S_RD1, 0);
      expect_out($sformatf("rst_rd2_%0d", a), S_RD2, 0);
      expect_out($sformatf("rst_b1_%0d", a), S_B1, 0);
      expect_out($sformatf("rst_b2_%0d", a), S_B2, 0);
      expect_out("rst_bany_loop", S_BANY, 0);
      sample();
    end

    // Port-0 bypass, then stored value.
    next_cycle();
    wrEn0 = 1'b1; wrAddr0 = 5; wrData0 = 32'hDEADBEEF; readAddr1 = 5;
    expect_out("byp0_rd1", S_RD1, 32'hDEADBEEF);
    sample();
    next_cycle();
    idle();
    expect_out("st0_rd1", S_RD1, 32'hDEADBEEF);
    sample();

    // Both ports to one address: port 1 wins in bypass and storage.
    next_cycle();
    wrEn0 = 1'b1; wrAddr0 = 7; wrData0 = 32'h11;
    wrEn1 = 1'b1; wrAddr1 = 7; wrData1 = 32'h22;
    readAddr1 = 7; readAddr2 = 7;
    expect_out("coll_byp_rd1", S_RD1, 32'h22);
    expect_out("coll_byp_rd2", S_RD2, 32'h22);
    sample();
    next_cycle();
    idle();
    expect_out("coll_st_rd2", S_RD2, 32'h22);
    sample();

    // Two ports to different addresses in one cycle both land.
    next_cycle();
    wrEn0 = 1'b1; wrAddr0 = 10; wrData0 = 32'hA0A0;
    wrEn1 = 1'b1; wrAddr1 = 11; wrData1 = 32'hB1B1;
    next_cycle();
    idle();
    readAddr1 = 10; readAddr2 = 11;
    expect_out("dual_rd1", S_RD1, 32'hA0A0);
    expect_out("dual_rd2", S_RD2, 32'hB1B1);
    sample();

    // Reserve 9, load returns on port 1.
    next_cycle();
    reserveEn = 1'b1; reserveAddr = 9; readAddr2 = 9;
    expect_out("rsv9_pre_b2", S_B2, 0);
    expect_out("rsv9_pre_bany", S_BANY, 0);
    sample();
    next_cycle();
    idle();
    expect_out("rsv9_b2", S_B2, 1);
    expect_out("rsv9_bany", S_BANY, 1);
    sample();
    next_cycle();
    wrEn1 = 1'b1; wrAddr1 = 9; wrData1 = 32'h55;
    expect_out("ld9_b2", S_B2, 0);
    expect_out("ld9_rd2", S_RD2, 32'h55);
    expect_out("ld9_bany", S_BANY, 1);
    sample();
    next_cycle();
    idle();
    expect_out("ld9_after_b2", S_B2, 0);
    expect_out("ld9_after_bany", S_BANY, 0);
    expect_out("ld9_after_rd2", S_RD2, 32'h55);
    sample();

    // Reserve and port-1 clear to the same address: reservation wins.
    next_cycle();
    reserveEn = 1'b1; reserveAddr = 3;
    wrEn1 = 1'b1; wrAddr1 = 3; wrData1 = 32'h33; readAddr1 = 3;
    expect_out("rc3_pre_b1", S_B1, 0);
    sample();
    next_cycle();
    idle();
    expect_out("rc3_b1", S_B1, 1);
    expect_out("rc3_rd1", S_RD1, 32'h33);
    expect_out("rc3_bany", S_BANY, 1);
    sample();
    next_cycle();
    wrEn1 = 1'b1; wrAddr1 = 3; wrData1 = 32'h44;
    next_cycle();
    idle();
    expect_out("rc3_clr_b1", S_B1, 0);
    expect_out("rc3_clr_bany", S_BANY, 0);
    sample();

    // Double reserve does not count; port 0 does not clear busy.
    next_cycle();
    reserveEn = 1'b1; reserveAddr = 12; readAddr2 = 12;
    next_cycle();
    reserveEn = 1'b1; reserveAddr = 12;
    next_cycle();
    idle();
    wrEn0 = 1'b1; wrAddr0 = 12; wrData0 = 32'hC0C0;
    expect_out("p0_nclr_b2_pre", S_B2, 1);
    sample();
    next_cycle();
    idle();
    expect_out("p0_nclr_b2", S_B2, 1);
    expect_out("p0_nclr_rd2", S_RD2, 32'hC0C0);
    sample();
    next_cycle();
    wrEn1 = 1'b1; wrAddr1 = 12; wrData1 = 32'hC1C1;
    next_cycle();
    idle();
    expect_out("dbl_rsv_b2", S_B2, 0);
    expect_out("dbl_rsv_bany", S_BANY, 0);
    sample();

    // Register 0: hardwired in one instance, ordinary in the other.
    next_cycle();
    wrEn0 = 1'b1; wrAddr0 = 0; wrData0 = 32'hFFFFFFFF;
    reserveEn = 1'b1; reserveAddr = 0; readAddr1 = 0;
    expect_out("r0_byp_rd1", S_RD1, 0);
    expect_out("r0z_byp_rd1", S_Z_RD1, 32'hFFFFFFFF);
    sample();
    next_cycle();
    idle();
    expect_out("r0_rd1", S_RD1, 0);
    expect_out("r0_b1", S_B1, 0);
    expect_out("r0_bany", S_BANY, 0);
    expect_out("r0z_rd1", S_Z_RD1, 32'hFFFFFFFF);
    expect_out("r0z_b1", S_Z_B1, 1);
    expect_out("r0z_bany", S_Z_BANY, 1);
    sample();
    next_cycle();
    wrEn1 = 1'b1; wrAddr1 = 0; wrData1 = 32'h1234;
    expect_out("r0_p1_byp_rd1", S_RD1, 0);
    expect_out("r0z_p1_b1", S_Z_B1, 0);
    sample();
    next_cycle();
    idle();

    // Asynchronous reset mid-operation drops state and reservations.
    reserveEn = 1'b1; reserveAddr = 20;
    wrEn0 = 1'b1; wrAddr0 = 21; wrData0 = 32'h2121;
    next_cycle();
    idle();
    readAddr1 = 21; readAddr2 = 20;
    expect_out("pre_rst_rd1", S_RD1, 32'h2121);
    expect_out("pre_rst_b2", S_B2, 1);
    sample();
    #2;
    rst = 1'b1;
    #1;
    expect_out("arst_rd1", S_RD1, 0);
    expect_out("arst_b2", S_B2, 0);
    expect_out("arst_bany", S_BANY, 0);
    drain();
    next_cycle();
    reserveEn = 1'b1; reserveAddr = 22;
    wrEn0 = 1'b1; wrAddr0 = 23; wrData0 = 32'h2323;
    next_cycle();
    idle();
    rst = 1'b0;
    readAddr1 = 23; readAddr2 = 22;
    expect_out("rst_ign_rd1", S_RD1, 0);
    expect_out("rst_ign_b2", S_B2, 0);
    expect_out("rst_ign_bany", S_BANY, 0);
    sample();

    if (q_sel.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", q_sel.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, data width of each register.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 SHALL have parameter ZERO_REG, default 1, where 1 hardwires register 0 to zero and 0 makes register 0 an ordinary register.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have wrEn0 / wrAddr0 / wrData0  input  1 / ADDR_WIDTH / BIT_WIDTH  write port 0 (ALU result).
REQ-007 SHALL have wrEn1 / wrAddr1 / wrData1  input  1 / ADDR_WIDTH / BIT_WIDTH  write port 1 (load return, clears busy).
REQ-008 SHALL have readAddr1, readAddr2  input  ADDR_WIDTH  read addresses.
REQ-009 SHALL have readData1, readData2  output  BIT_WIDTH  read data, combinational.
REQ-010 SHALL have reserveEn / reserveAddr  input  1 / ADDR_WIDTH  mark a register busy (outstanding load).
REQ-011 SHALL have busy1, busy2  output  1  busy bit of readAddr1 / readAddr2, combinational.
REQ-012 SHALL have busyAny  output  1  OR of all busy bits, registered state only.

Function
REQ-013 SHALL write wrData0 to registers[wrAddr0] on the rising clk edge when wrEn0=1.
REQ-014 SHALL write wrData1 to registers[wrAddr1] on the rising clk edge when wrEn1=1.
REQ-015 SHALL have port 1 win when both ports write the same address in one cycle; the port 0 data is discarded.
REQ-016 SHALL ignore writes to address 0 when ZERO_REG=1, and SHALL then return 0 for reads of address 0 with busy reported as 0.
REQ-017 SHALL make readDataN equal registers[readAddrN] when no same-cycle write targets readAddrN.
REQ-018 SHALL bypass same-cycle writes: if wrEn1 targets readAddrN, readDataN = wrData1; else if wrEn0 targets readAddrN, readDataN = wrData0; latency 0.
REQ-019 SHALL keep one busy bit per register; reserveEn=1 sets busy[reserveAddr] at the clock edge.
REQ-020 SHALL clear busy[wrAddr1] at the clock edge when wrEn1=1; wrEn0 SHALL NOT affect busy bits.
REQ-021 SHALL set busy when reserve and a port-1 clear hit the same address in the same cycle (new reservation wins).
REQ-022 SHALL leave busy unchanged when reserveEn sets an already-busy register (no counting, no error).
REQ-023 SHALL report busyN = busy[readAddrN] AND NOT (wrEn1 AND wrAddr1==readAddrN), so a load returning this cycle is not stalled on.
REQ-024 SHALL ignore a reserve of address 0 when ZERO_REG=1.
REQ-025 SHALL leave registers and busy bits unchanged in any cycle with no enables asserted.

Reset
REQ-026 SHALL, while rst=1, asynchronously force all registers to 0 and all busy bits to 0, so readData1/2=0 and busy1/2=0 when no bypass applies, and busyAny=0.
REQ-027 SHALL ignore writes and reserves on any clock edge where rst=1; on rst deassertion mid-operation, outstanding reservations SHALL be lost.

Verification
REQ-028 SHALL pass this check: rst pulse, then read all addresses -> every readData=0, busy1/2=0, busyAny=0.
REQ-029 SHALL pass this check: wrEn0=1, wrAddr0=5, wrData0=0xDEADBEEF, readAddr1=5 in the same cycle -> readData1=0xDEADBEEF before the edge; after the edge readData1=0xDEADBEEF with wrEn0=0.
REQ-030 SHALL pass this check: wrEn0 and wrEn1 both to address 7, data 0x11 / 0x22 -> bypass and stored value are both 0x22.
REQ-031 SHALL pass this check: reserve address 9, then readAddr2=9 -> busy2=1 and busyAny=1; wrEn1 to 9 with 0x55 -> busy2=0 that cycle with readData2=0x55; next cycle busy2=0 and busyAny=0.
REQ-032 SHALL pass this check: reserveEn to 3 and wrEn1 to 3 in the same cycle -> busy[3]=1 after the edge.
REQ-033 SHALL pass this check with ZERO_REG=1: write 0xFFFFFFFF to 0 and reserve 0 -> readData1=0 and busy1=0 at readAddr1=0; with ZERO_REG=0 the same stimulus -> 0xFFFFFFFF and busy1=1.
